// File: rtl/div8_pkg.sv
// Shared types and elaboration helpers for the iterative restoring divider.
// The helper functions let the top size its counter for any legal BITS_PER_CYCLE.
package div8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_W   = 8;
  localparam int DIV_BPC = 1;
  localparam int CNT_W   = $clog2(DIV_W / DIV_BPC + 1);

  function automatic bit legal_bpc(input int w, input int bpc);
    return (bpc == 1 || bpc == 2 || bpc == 4 || bpc == 8) && (bpc <= w) && (w % bpc == 0);
  endfunction

  function automatic int cnt_width(input int w, input int bpc);
    return $clog2(w / bpc + 1);
  endfunction

endpackage

// File: rtl/div8_if.sv
// Operand/result bundle for div8_iter, plus the FSM state as a debug view.
// Handshake: a beat moves on a rising edge where valid & ready are both 1; the
// producer keeps valid (and its data) until that edge, ready never waits on valid.
interface div8_if #(parameter int W = 8);
  import div8_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] A;
  logic [W-1:0]   B;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   Q;
  logic [W-1:0]   R;
  logic           div0;
  logic           ovf;
  div_state_t     state;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Q, R, div0, ovf, state
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Q, R, div0, ovf, state
  );

endinterface

// File: rtl/div8_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor if it fits. The partial remainder carries one guard bit above W.
module div8_step #(
  parameter int W = 8
) (
  input  logic [W:0]   rem_in,
  input  logic [W-1:0] b,
  input  logic         bit_in,
  output logic [W:0]   rem_out,
  output logic         q_bit
);

  logic [W+1:0] shifted;
  logic [W:0]   diff;

  assign shifted = {rem_in, bit_in};
  assign q_bit   = (shifted >= {2'b00, b});
  // When the subtraction is taken the result is below b, so W+1 bits suffice.
  assign diff    = shifted[W:0] - {1'b0, b};
  assign rem_out = q_bit ? diff : shifted[W:0];

endmodule

// File: rtl/div8_iter.sv
// Iterative unsigned restoring divider, 2W-bit dividend by W-bit divisor,
// resolving BITS_PER_CYCLE quotient bits per clock with valid/ready on both sides.
module div8_iter
  import div8_pkg::*;
#(
  parameter int W              = DIV_W,
  parameter int BITS_PER_CYCLE = DIV_BPC
) (
  input logic   clk,
  input logic   rst,
  div8_if.slave io
);

  localparam int K        = W / BITS_PER_CYCLE;
  localparam int CW       = cnt_width(W, BITS_PER_CYCLE);
  localparam bit ONE_SHOT = (K == 1);

  generate
    if (!legal_bpc(W, BITS_PER_CYCLE)) begin : g_bad_bpc
      $error("div8_iter: BITS_PER_CYCLE=%0d is not legal for W=%0d", BITS_PER_CYCLE, W);
    end
  endgenerate

  div_state_t state, state_n;

  logic [CW-1:0] cnt;
  logic [W:0]    rem;
  logic [W-1:0]  dvd;
  logic [W-1:0]  b_r;

  logic [W:0]    rem_chain [0:BITS_PER_CYCLE];
  logic [W-1:0]  dvd_chain [0:BITS_PER_CYCLE];
  logic [BITS_PER_CYCLE-1:0] q_bit;
  logic [W-1:0]  b_sel;

  logic idle;
  logic accept;
  logic is_div0;
  logic is_ovf;
  logic last_calc;

  assign idle      = (state == IDLE);
  assign accept    = io.in_valid & io.in_ready;
  assign is_div0   = (io.B == '0);
  assign is_ovf    = (io.A[2*W-1:W] >= io.B);
  assign last_calc = (cnt == CW'(1));

  // The accepting edge already runs the first group of steps on the live
  // operands, which is what gives K-edge latency and K+1 throughput.
  assign rem_chain[0] = idle ? {1'b0, io.A[2*W-1:W]} : rem;
  assign dvd_chain[0] = idle ? io.A[W-1:0] : dvd;
  assign b_sel        = idle ? io.B : b_r;

  // The low dividend register doubles as the quotient: each step shifts one
  // dividend bit out of the top and one quotient bit into the bottom.
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    div8_step #(.W(W)) u_step (
      .rem_in  (rem_chain[i]),
      .b       (b_sel),
      .bit_in  (dvd_chain[i][W-1]),
      .rem_out (rem_chain[i+1]),
      .q_bit   (q_bit[i])
    );
    assign dvd_chain[i+1] = {dvd_chain[i][W-2:0], q_bit[i]};
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_div0 || is_ovf || ONE_SHOT) state_n = DONE;
          else                               state_n = CALC;
        end
      end
      CALC: begin
        if (last_calc) state_n = DONE;
      end
      DONE: begin
        if (io.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign io.state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      io.in_ready  <= 1'b1;
      io.out_valid <= 1'b0;
      io.Q         <= '0;
      io.R         <= '0;
      io.div0      <= 1'b0;
      io.ovf       <= 1'b0;
      cnt          <= '0;
      rem          <= '0;
      dvd          <= '0;
      b_r          <= '0;
    end else begin
      state        <= state_n;
      io.in_ready  <= (state_n == IDLE);
      io.out_valid <= (state_n == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            b_r <= io.B;
            cnt <= CW'(K - 1);
            rem <= rem_chain[BITS_PER_CYCLE];
            dvd <= dvd_chain[BITS_PER_CYCLE];
            if (is_div0) begin
              io.Q    <= '1;
              io.R    <= io.A[W-1:0];
              io.div0 <= 1'b1;
              io.ovf  <= 1'b0;
            end else if (is_ovf) begin
              io.Q    <= '1;
              io.R    <= '0;
              io.div0 <= 1'b0;
              io.ovf  <= 1'b1;
            end else if (ONE_SHOT) begin
              io.Q    <= dvd_chain[BITS_PER_CYCLE];
              io.R    <= rem_chain[BITS_PER_CYCLE][W-1:0];
              io.div0 <= 1'b0;
              io.ovf  <= 1'b0;
            end
          end
        end
        CALC: begin
          rem <= rem_chain[BITS_PER_CYCLE];
          dvd <= dvd_chain[BITS_PER_CYCLE];
          cnt <= cnt - CW'(1);
          if (last_calc) begin
            io.Q    <= dvd_chain[BITS_PER_CYCLE];
            io.R    <= rem_chain[BITS_PER_CYCLE][W-1:0];
            io.div0 <= 1'b0;
            io.ovf  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div8_iter.sv
// Directed bench for div8_iter: main instance at BITS_PER_CYCLE=1 plus
// instances at 2, 4 and 8 sharing the same input stimulus.
module tb_div8_iter;
  import div8_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div8_if #(.W(8)) bus ();

  div8_iter #(.W(8), .BITS_PER_CYCLE(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  logic       alt_ov [3];
  logic       alt_ir [3];
  logic [7:0] alt_q  [3];
  logic [7:0] alt_r  [3];
  logic [1:0] alt_fl [3];
  div_state_t alt_st [3];

  for (genvar i = 0; i < 3; i++) begin : g_alt
    localparam int BPC = 2 << i;
    div8_if #(.W(8)) alt_if ();
    assign alt_if.in_valid  = bus.in_valid;
    assign alt_if.A         = bus.A;
    assign alt_if.B         = bus.B;
    assign alt_if.out_ready = bus.out_ready;
    div8_iter #(.W(8), .BITS_PER_CYCLE(BPC)) u_alt (
      .clk (clk),
      .rst (rst),
      .io  (alt_if)
    );
    assign alt_ov[i] = alt_if.out_valid;
    assign alt_ir[i] = alt_if.in_ready;
    assign alt_q[i]  = alt_if.Q;
    assign alt_r[i]  = alt_if.R;
    assign alt_fl[i] = {alt_if.div0, alt_if.ovf};
    assign alt_st[i] = alt_if.state;
  end

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  // ---------------- clock / reset ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic d0, input logic ov, input int lat);
    int n;
    logic [15:0] e;
    check({tag, "/in_ready"}, 32'(bus.in_ready), 32'd1);
    exp_q.push_back({eq, er});
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.A        = 16'hDEAD;
    bus.B        = 8'h5A;
    n = 1;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "/latency"}, 32'(n), 32'(lat));
    e = exp_q.pop_front();
    check({tag, "/q"}, 32'(bus.Q), 32'(e[15:8]));
    check({tag, "/r"}, 32'(bus.R), 32'(e[7:0]));
    check({tag, "/div0"}, 32'(bus.div0), 32'(d0));
    check({tag, "/ovf"}, 32'(bus.ovf), 32'(ov));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "/drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic backpressure();
    int n;
    bus.A        = 16'h3039;
    bus.B        = 8'h7B;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    check("bp/latency", 32'(n), 32'd8);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.A        = 16'h0101 + 16'(i);
      bus.B        = 8'h03;
      tick();
      check("bp/valid", 32'(bus.out_valid), 32'd1);
      check("bp/in_ready", 32'(bus.in_ready), 32'd0);
      check("bp/q", 32'(bus.Q), 32'h64);
      check("bp/r", 32'(bus.R), 32'h2D);
      check("bp/flags", 32'({bus.div0, bus.ovf}), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp/release_valid", 32'(bus.out_valid), 32'd0);
    check("bp/release_ready", 32'(bus.in_ready), 32'd1);
    check("bp/release_state", 32'(bus.state), 32'(IDLE));
    check("bp/q_held", 32'(bus.Q), 32'h64);
    tick();
    tick();
    check("bp/nothing_queued", 32'(bus.out_valid), 32'd0);
    check("bp/still_idle", 32'(bus.state), 32'(IDLE));
  endtask

  task automatic mid_reset();
    bus.A        = 16'h3039;
    bus.B        = 8'h7B;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("mr/calc", 32'(bus.state), 32'(CALC));
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr/valid", 32'(bus.out_valid), 32'd0);
    check("mr/in_ready", 32'(bus.in_ready), 32'd1);
    check("mr/q", 32'(bus.Q), 32'd0);
    check("mr/r", 32'(bus.R), 32'd0);
    check("mr/state", 32'(bus.state), 32'(IDLE));
    run_op("post_rst", 16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 8);
  endtask

  task automatic throughput();
    logic [15:0] va [3] = '{16'h2710, 16'h02FD, 16'h2711};
    logic [7:0]  vb [3] = '{8'h32, 8'hFF, 8'h32};
    logic [15:0] ve [3] = '{16'hC800, 16'h0300, 16'hC801};
    int acc[$];
    int cyc = 0;
    int got = 0;
    int idx = 0;
    logic taken;
    logic [15:0] e;
    bus.out_ready = 1'b1;
    bus.A         = va[0];
    bus.B         = vb[0];
    bus.in_valid  = 1'b1;
    while (got < 3 && cyc < 80) begin
      if (bus.out_valid) begin
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else                   e = 16'hxxxx;
        check("tp/q", 32'(bus.Q), 32'(e[15:8]));
        check("tp/r", 32'(bus.R), 32'(e[7:0]));
        got++;
      end
      taken = bus.in_valid && bus.in_ready;
      if (taken) begin
        acc.push_back(cyc);
        exp_q.push_back(ve[idx]);
        idx++;
      end
      tick();
      cyc++;
      if (taken) begin
        if (idx < 3) begin
          bus.A = va[idx];
          bus.B = vb[idx];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("tp/results", 32'(got), 32'd3);
    check("tp/gap1", (acc.size() >= 2) ? 32'(acc[1] - acc[0]) : 32'hFFFF_FFFF, 32'd9);
    check("tp/gap2", (acc.size() >= 3) ? 32'(acc[2] - acc[1]) : 32'hFFFF_FFFF, 32'd9);
    exp_q.delete();
  endtask

  task automatic multi_bpc(input logic [7:0] a, input logic [7:0] b);
    int lat_main;
    int lat_alt [3];
    logic [15:0] prod;
    prod     = {8'h00, a} * {8'h00, b};
    lat_main = 0;
    lat_alt  = '{0, 0, 0};
    check("mb/in_ready", 32'(bus.in_ready), 32'd1);
    bus.A        = prod;
    bus.B        = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      if (bus.out_valid && lat_main == 0) lat_main = n;
      for (int i = 0; i < 3; i++)
        if (alt_ov[i] && lat_alt[i] == 0) lat_alt[i] = n;
      if (n < 9) tick();
    end
    check("mb1/latency", 32'(lat_main), 32'd8);
    check("mb1/q", 32'(bus.Q), 32'(a));
    check("mb1/r", 32'(bus.R), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mb%0d/latency", 2 << i), 32'(lat_alt[i]), 32'(4 >> i));
      check($sformatf("mb%0d/q", 2 << i), 32'(alt_q[i]), 32'(a));
      check($sformatf("mb%0d/r", 2 << i), 32'(alt_r[i]), 32'd0);
      check($sformatf("mb%0d/flags", 2 << i), 32'(alt_fl[i]), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("mb1/drained", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mb%0d/drained", 2 << i), 32'(alt_ov[i]), 32'd0);
      check($sformatf("mb%0d/idle", 2 << i), 32'(alt_st[i]), 32'(IDLE));
      check($sformatf("mb%0d/in_ready", 2 << i), 32'(alt_ir[i]), 32'd1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    do_reset();
    check("rst/out_valid", 32'(bus.out_valid), 32'd0);
    check("rst/in_ready", 32'(bus.in_ready), 32'd1);
    check("rst/q", 32'(bus.Q), 32'd0);
    check("rst/r", 32'(bus.R), 32'd0);
    check("rst/flags", 32'({bus.div0, bus.ovf}), 32'd0);
    check("rst/state", 32'(bus.state), 32'(IDLE));

    run_op("basic",    16'h3039, 8'h7B, 8'h64, 8'h2D, 1'b0, 1'b0, 8);
    run_op("div0",     16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, 1);
    run_op("ovf",      16'hFF00, 8'h10, 8'hFF, 8'h00, 1'b0, 1'b1, 1);
    run_op("ovf_eq",   16'h1010, 8'h10, 8'hFF, 8'h00, 1'b0, 1'b1, 1);
    run_op("edge_max", 16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 8);
    run_op("wide_rem", 16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0, 8);
    run_op("big_b",    16'h7FFF, 8'h80, 8'hFF, 8'h7F, 1'b0, 1'b0, 8);

    backpressure();
    mid_reset();
    throughput();

    do_reset();
    multi_bpc(8'd1,   8'd1);
    multi_bpc(8'd255, 8'd255);
    multi_bpc(8'd128, 8'd2);
    multi_bpc(8'd17,  8'd13);
    multi_bpc(8'd200, 8'd255);
    multi_bpc(8'd1,   8'd255);
    multi_bpc(8'd255, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
